muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 19 +
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_ctrl.sv | 159 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: definitions shared by the multiply/divide controller and
// the ALU decoder.
//   WIDTH_DEFAULT      - default operand / HI / LO width
//   ALU_MULT, ALU_DIV  - alucontrol encodings of the two HI/LO operations
//   state_t            - controller FSM states
package muldiv_ctrl_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of the unsigned iterative multiplier/divider.
//   i_div  - 1: restoring-subtract step, 0: shift-add step
//   i_acc  - partial product (MULT) / partial remainder (DIV)
//   i_mq   - multiplier bits still to consume (MULT) / dividend bits
//            shifting out while quotient bits shift in (DIV)
//   i_opnd - multiplicand magnitude (MULT) / divisor magnitude (DIV)
//   o_acc, o_mq - values after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_mq,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_mq
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum     = {1'b0, i_acc} + {1'b0, (i_mq[0] ? i_opnd : '0)};
        w_shifted = {i_acc, i_mq[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, i_opnd};
        if (i_div) begin
            // Top bit of the difference is the borrow: set means "restore".
            if (!w_diff[WIDTH]) begin
                o_acc = w_diff[WIDTH-1:0];
                o_mq  = {i_mq[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_shifted[WIDTH-1:0];
                o_mq  = {i_mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Carry of the add shifts into the accumulator MSB; the
            // accumulator LSB becomes the next product bit in i_mq.
            o_acc = w_sum[WIDTH:1];
            o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative signed MULT/DIV unit owning the HI/LO registers.
//   clk, reset (async, active-low)
//   start, alucontrol, srca, srcb - operation request from EX
//   mfreq  - MFHI/MFLO in EX wants HI/LO
//   flush  - abort any operation in progress
//   busy   - FSM not IDLE
//   stall  - freeze IF/ID/EX while busy and EX needs this unit
//   hi, lo - result registers
//   done   - one-cycle pulse in the first cycle a new result is visible
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mfreq,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_divzero;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic               w_is_mult;
    logic               w_is_div;
    logic               w_accept;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_acc_nx;
    logic [WIDTH-1:0]   w_mq_nx;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_is_mult = (alucontrol == ALU_MULT);
    assign w_is_div  = (alucontrol == ALU_DIV);
    assign w_accept  = start & ~flush & (w_is_mult | w_is_div);

    // Magnitude of the most negative value is itself, read as unsigned.
    assign w_abs_a = srca[WIDTH-1] ? (~srca + 1'b1) : srca;
    assign w_abs_b = srcb[WIDTH-1] ? (~srcb + 1'b1) : srcb;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div  (r_is_div),
        .i_acc  (r_acc),
        .i_mq   (r_mq),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_nx),
        .o_mq   (w_mq_nx)
    );

    // Sign correction: quotient/product negative when signs differ,
    // remainder follows the dividend.
    assign w_prod_fix = r_neg_q ? (~{r_acc, r_mq} + 1'b1) : {r_acc, r_mq};
    assign w_q_fix    = r_neg_q ? (~r_mq + 1'b1) : r_mq;
    assign w_r_fix    = r_neg_r ? (~r_acc + 1'b1) : r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_divzero <= 1'b0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_div <= w_is_div;
                        r_neg_q  <= srca[WIDTH-1] ^ srcb[WIDTH-1];
                        r_neg_r  <= srca[WIDTH-1];
                        r_cnt    <= CNT_LAST;
                        if (w_is_div && (srcb == '0)) begin
                            // Divide by zero: raw dividend parked in r_acc for HI.
                            r_divzero <= 1'b1;
                            r_acc     <= srca;
                            r_mq      <= '0;
                            r_opnd    <= '0;
                            r_state   <= FIXUP;
                        end else begin
                            r_divzero <= 1'b0;
                            r_acc     <= '0;
                            r_mq      <= w_is_div ? w_abs_a : w_abs_b;
                            r_opnd    <= w_is_div ? w_abs_b : w_abs_a;
                            r_state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc <= w_acc_nx;
                        r_mq  <= w_mq_nx;
                        if (r_cnt == '0) begin
                            r_state <= FIXUP;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                FIXUP: begin
                    r_state <= IDLE;
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_divzero) begin
                            r_hi <= r_acc;
                            r_lo <= '1;
                        end else if (r_is_div) begin
                            r_hi <= w_r_fix;
                            r_lo <= w_q_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = (r_state != IDLE);
    assign stall = busy & (start | mfreq);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign done  = r_done;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   alucontrol = '0;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic         mfreq = 1'b0;
    logic         flush = 1'b0;
    logic         busy;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         done;

    int tests = 0;
    int fails = 0;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .mfreq      (mfreq),
        .flush      (flush),
        .busy       (busy),
        .stall      (stall),
        .hi         (hi),
        .lo         (lo),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == ALU_MULT) begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (b == '0) begin
            eh = a;
            el = '1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    // Bounded wait for done; checks edges elapsed since the accept edge.
    task automatic wait_done(input int exp_edges, input string tag);
        int n;
        n = 0;
        while (!done && n < 100) begin
            tick;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_edges));
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] eh, el;
        model(op, a, b, eh, el);
        alucontrol = op;
        srca = a;
        srcb = b;
        start = 1'b1;
        tick;
        start = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'(1'b1));
        wait_done((op == ALU_DIV && b == '0) ? 1 : W + 1, tag);
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        tick;
        check({tag, " done pulse"}, 64'(done), 64'(1'b0));
    endtask

    initial begin
        logic [W-1:0] eh, el, a, b;
        logic [3:0]   op;
        int           dn;

        // Reset state
        #2;
        check("reset busy", 64'(busy), 64'(1'b0));
        check("reset stall", 64'(stall), 64'(1'b0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        check("reset done", 64'(done), 64'(1'b0));
        #10;
        reset = 1'b1;
        tick;

        // Directed operations
        run_op(ALU_MULT, 32'd7, 32'hFFFFFFFD, "mult 7*-3");
        check("mult 7*-3 hi const", 64'(hi), 64'(32'hFFFFFFFF));
        check("mult 7*-3 lo const", 64'(lo), 64'(32'hFFFFFFEB));
        run_op(ALU_DIV, 32'hFFFFFFF9, 32'd2, "div -7/2");
        run_op(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, "div min/-1");
        check("div min/-1 lo const", 64'(lo), 64'(32'h80000000));
        run_op(ALU_DIV, 32'd5, 32'd0, "div 5/0");

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            op = ($urandom_range(1, 0) == 1) ? ALU_DIV : ALU_MULT;
            case ($urandom_range(3, 0))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(200, 0) - 32'd100; b = $urandom_range(20, 0) - 32'd10; end
                2: begin a = $urandom; b = '0; end
                default: begin a = 32'h80000000; b = $urandom_range(3, 0) - 32'd2; end
            endcase
            run_op(op, a, b, "random");
        end

        // mfreq during CALC stalls until FIXUP ends
        model(ALU_MULT, 32'd12345, 32'hFFFFFD5A, eh, el);
        alucontrol = ALU_MULT;
        srca = 32'd12345;
        srcb = 32'hFFFFFD5A;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        mfreq = 1'b1;
        #1;
        check("mfreq stall first", 64'(stall), 64'(1'b1));
        for (int i = 0; i < 60 && !done; i++) begin
            tick;
            if (!done) check("mfreq stall", 64'(stall), 64'(1'b1));
        end
        check("mfreq done seen", 64'(done), 64'(1'b1));
        check("mfreq stall in done", 64'(stall), 64'(1'b0));
        check("mfreq hi", 64'(hi), 64'(eh));
        check("mfreq lo", 64'(lo), 64'(el));
        mfreq = 1'b0;
        tick;

        // Flush in CALC leaves HI/LO and gives no done
        run_op(ALU_DIV, 32'd7, 32'd3, "div 7/3");
        alucontrol = ALU_DIV;
        srca = 32'd1000;
        srcb = 32'd7;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'(1'b0));
        check("flush hi", 64'(hi), 64'(1));
        check("flush lo", 64'(lo), 64'(2));
        dn = 0;
        repeat (40) begin
            if (done) dn++;
            tick;
        end
        check("flush no done", 64'(dn), 64'(0));
        check("flush hi later", 64'(hi), 64'(1));

        // start with flush in IDLE is not accepted
        alucontrol = ALU_MULT;
        start = 1'b1;
        flush = 1'b1;
        tick;
        check("start+flush busy", 64'(busy), 64'(1'b0));
        start = 1'b0;
        flush = 1'b0;
        tick;
        check("start+flush busy later", 64'(busy), 64'(1'b0));

        // Asynchronous reset mid-MULT, then accept on the first edge after release
        run_op(ALU_MULT, 32'd3, 32'd5, "mult 3*5");
        model(ALU_MULT, 32'd100, 32'd200, eh, el);
        alucontrol = ALU_MULT;
        srca = 32'd100;
        srcb = 32'd200;
        start = 1'b1;
        tick;
        repeat (10) tick;
        check("pre-reset stall", 64'(stall), 64'(1'b1));
        #3;
        reset = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'(1'b0));
        check("async reset stall", 64'(stall), 64'(1'b0));
        check("async reset hi", 64'(hi), 64'(0));
        check("async reset lo", 64'(lo), 64'(0));
        #1;
        reset = 1'b1;
        tick;
        start = 1'b0;
        check("post-reset accept", 64'(busy), 64'(1'b1));
        wait_done(W + 1, "post-reset mult");
        check("post-reset hi", 64'(hi), 64'(eh));
        check("post-reset lo", 64'(lo), 64'(el));
        tick;

        // Back-to-back MULT with second start held through the first
        alucontrol = ALU_MULT;
        srca = 32'hFFFFFFFB;
        srcb = 32'd9;
        start = 1'b1;
        tick;
        srca = 32'd11;
        srcb = 32'hFFFFFFF3;
        #1;
        check("b2b held stall", 64'(stall), 64'(1'b1));
        model(ALU_MULT, 32'hFFFFFFFB, 32'd9, eh, el);
        wait_done(W + 1, "b2b first");
        check("b2b first hi", 64'(hi), 64'(eh));
        check("b2b first lo", 64'(lo), 64'(el));
        check("b2b stall in done", 64'(stall), 64'(1'b0));
        tick;
        start = 1'b0;
        check("b2b second accept", 64'(busy), 64'(1'b1));
        model(ALU_MULT, 32'd11, 32'hFFFFFFF3, eh, el);
        wait_done(W + 1, "b2b second");
        check("b2b second hi", 64'(hi), 64'(eh));
        check("b2b second lo", 64'(lo), 64'(el));
        tick;
        check("b2b done pulse", 64'(done), 64'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
